// File: rtl/pool_row_writer_if.sv
// pool_row_writer_if: row stream from the pooling stage plus the output RAM write bus.
interface pool_row_writer_if #(
    parameter int DATA_SIZE  = 16,
    parameter int ARRAY_SIZE = 9,
    parameter int ADDR_WIDTH = 10
);
    logic                            row_valid;
    logic                            row_ready;
    logic [DATA_SIZE*ARRAY_SIZE-1:0] row_data;
    logic                            mem_we;
    logic [ADDR_WIDTH-1:0]           mem_addr;
    logic [DATA_SIZE-1:0]            mem_wdata;
    modport master (output row_valid, row_data, input row_ready, mem_we, mem_addr, mem_wdata);
    modport slave  (input row_valid, row_data, output row_ready, mem_we, mem_addr, mem_wdata);
endinterface

// File: rtl/pool_row_writer.sv
// pool_row_writer: buffers pooled rows in a FIFO and serialises them into sequential RAM writes.
// Defining WB_CHECKSUM_EN adds a 32-bit running sum of all written words.
module pool_row_writer #(
    parameter int DATA_SIZE  = 16,
    parameter int ARRAY_SIZE = 9,
    parameter int ADDR_WIDTH = 10,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  s_clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [15:0]           num_rows,
    pool_row_writer_if.slave      bus,
    output logic                  busy,
    output logic                  done
`ifdef WB_CHECKSUM_EN
    ,
    output logic [31:0]           checksum
`endif
);
    localparam int RW = DATA_SIZE * ARRAY_SIZE;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = (ARRAY_SIZE > 1) ? $clog2(ARRAY_SIZE) : 1;
    localparam logic [PW:0]   FULL = (PW+1)'(FIFO_DEPTH);
    localparam logic [LW-1:0] LAST = LW'(ARRAY_SIZE - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t                state, state_n;
    logic [RW-1:0]         fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic [PW:0]           count;
    logic [RW-1:0]         row_q;
    logic [LW-1:0]         lane_idx;
    logic                  lane_vld;
    logic [ADDR_WIDTH-1:0] addr_cnt;
    logic [15:0]           nrows_q, rows_acc, rows_done;
    logic                  fire, push, pop, wr, last_lane, last_write;
    logic [DATA_SIZE-1:0]  lane_data;

    assign fire          = state == S_IDLE && start;
    assign bus.row_ready = state == S_RUN && count != FULL && rows_acc < nrows_q;
    assign push          = bus.row_valid && bus.row_ready;
    assign last_lane     = lane_idx == LAST;
    assign wr            = lane_vld && enable;
    // A row is popped while the final lane of the previous one is written, so rows stream gap-free.
    assign pop           = enable && count != '0 && (!lane_vld || last_lane);
    assign last_write    = wr && last_lane && rows_done == nrows_q - 16'd1;
    assign lane_data     = row_q[lane_idx*DATA_SIZE +: DATA_SIZE];
    assign busy          = state == S_RUN;
    assign done          = state == S_DONE;

    always_ff @(posedge s_clk or posedge reset)
        if (reset) state <= S_IDLE;
        else       state <= state_n;

    always_comb begin
        state_n = state;
        if (fire) state_n = S_RUN;
        else if (state == S_RUN && (nrows_q == '0 || last_write)) state_n = S_DONE;
        else if (state == S_DONE) state_n = S_IDLE;
    end

    always_ff @(posedge s_clk)
        if (push) fifo_mem[wr_ptr] <= bus.row_data;

    always_ff @(posedge s_clk or posedge reset) begin
        if (reset) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            row_q         <= '0;
            lane_idx      <= '0;
            lane_vld      <= 1'b0;
            addr_cnt      <= '0;
            nrows_q       <= '0;
            rows_acc      <= '0;
            rows_done     <= '0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
        end else begin
            bus.mem_we <= wr;
            if (wr) begin
                bus.mem_addr  <= addr_cnt;
                bus.mem_wdata <= lane_data;
                addr_cnt      <= addr_cnt + 1'b1;
                lane_idx      <= last_lane ? '0 : lane_idx + 1'b1;
                if (last_lane) rows_done <= rows_done + 16'd1;
            end
            if (pop) begin
                row_q    <= fifo_mem[rd_ptr];
                rd_ptr   <= rd_ptr + 1'b1;
                lane_vld <= 1'b1;
                lane_idx <= '0;
            end else if (wr && last_lane) begin
                lane_vld <= 1'b0;
            end
            if (push) wr_ptr <= wr_ptr + 1'b1;
            count    <= count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
            rows_acc <= rows_acc + {15'd0, push};
            if (fire) begin
                addr_cnt  <= base_addr;
                nrows_q   <= num_rows;
                rows_acc  <= '0;
                rows_done <= '0;
            end
        end
    end

`ifdef WB_CHECKSUM_EN
    always_ff @(posedge s_clk or posedge reset)
        if (reset)     checksum <= '0;
        else if (fire) checksum <= '0;
        else if (wr)   checksum <= checksum + 32'(lane_data);
`endif

endmodule

// File: tb/tb_pool_row_writer.sv
// tb_pool_row_writer: randomized and directed jobs checked against an address/data model of the row writer.
module tb_pool_row_writer;
    localparam int DS = 16, AS = 9, AW = 10, FD = 4, RW = DS * AS;

    logic          s_clk = 0, reset = 0, enable = 0, start = 0;
    logic [AW-1:0] base_addr = '0;
    logic [15:0]   num_rows = '0;
    logic          busy, done;
`ifdef WB_CHECKSUM_EN
    logic [31:0]   checksum;
`endif

    pool_row_writer_if #(.DATA_SIZE(DS), .ARRAY_SIZE(AS), .ADDR_WIDTH(AW)) bus();

    pool_row_writer #(.DATA_SIZE(DS), .ARRAY_SIZE(AS), .ADDR_WIDTH(AW), .FIFO_DEPTH(FD)) dut (
        .s_clk(s_clk), .reset(reset), .enable(enable), .start(start),
        .base_addr(base_addr), .num_rows(num_rows), .bus(bus),
        .busy(busy), .done(done)
`ifdef WB_CHECKSUM_EN
        , .checksum(checksum)
`endif
    );

    always #5 s_clk = ~s_clk;

    int            vectors = 0, errors = 0, cyc = 0, done_cnt = 0;
    bit            we_seen, ready_seen;
    logic [AW-1:0] got_addr [$];
    logic [DS-1:0] got_data [$];
    int            got_cyc [$];
    logic [RW-1:0] job_rows [$];

    always @(posedge s_clk) cyc <= cyc + 1;

    always @(negedge s_clk) begin
        if (bus.mem_we) begin
            got_addr.push_back(bus.mem_addr);
            got_data.push_back(bus.mem_wdata);
            got_cyc.push_back(cyc);
            we_seen = 1;
        end
        if (done) done_cnt++;
        if (bus.row_ready) ready_seen = 1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge s_clk);
        #1;
    endtask

    function automatic logic [RW-1:0] rand_row();
        logic [RW-1:0] r;
        for (int l = 0; l < AS; l++) r[l*DS +: DS] = DS'($urandom);
        return r;
    endfunction

    function automatic logic [RW-1:0] seq_row(input int first);
        logic [RW-1:0] r;
        for (int l = 0; l < AS; l++) r[l*DS +: DS] = DS'(first + l);
        return r;
    endfunction

    task automatic check_zero();
        check("rst_row_ready", bus.row_ready, 0);
        check("rst_mem_we", bus.mem_we, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_mem_addr", bus.mem_addr, 0);
        check("rst_mem_wdata", bus.mem_wdata, 0);
`ifdef WB_CHECKSUM_EN
        check("rst_checksum", checksum, 0);
`endif
    endtask

    // Expected writes: row r lane l lands at base + r*AS + l (mod 2^AW), carrying that lane's value.
    task automatic run_job(input logic [AW-1:0] base, input int n, input bit en_rand,
                           input bit val_rand, input int off, input bit spurious);
        int          i = 0, c = 0, d0, idx;
        bit          acc;
        logic [31:0] sum = 0;
        logic [DS-1:0] ed;
        got_addr.delete(); got_data.delete(); got_cyc.delete();
        d0 = done_cnt;
        base_addr = base; num_rows = 16'(n); start = 1;
        tick();
        start = 0;
        while (done_cnt == d0 && c < 2000) begin
            if (off > 0 && c == off) begin
                check("stall_accepted", i, (n < FD) ? n : FD);
                check("stall_ready", bus.row_ready, 0);
            end
            enable = (c < off) ? 1'b0 : en_rand ? ($urandom_range(3) != 0) : 1'b1;
            start = spurious && c == 3;
            base_addr = start ? ~base : base;
            num_rows = start ? 16'(n + 5) : 16'(n);
            bus.row_valid = i < n && (!val_rand || $urandom_range(2) != 0);
            bus.row_data = (i < n) ? job_rows[i] : '0;
            @(negedge s_clk);
            acc = bus.row_valid && bus.row_ready;
            tick();
            if (acc) i++;
            c++;
        end
        start = 0; bus.row_valid = 0; enable = 1;
        check("job_finished", c < 2000, 1);
        check("rows_accepted", i, n);
        repeat (2) tick();
        check("done_pulses", done_cnt - d0, 1);
        check("busy_after", busy, 0);
        check("write_count", got_addr.size(), n * AS);
        for (int r = 0; r < n; r++)
            for (int l = 0; l < AS; l++) begin
                idx = r * AS + l;
                ed = job_rows[r][l*DS +: DS];
                sum += 32'(ed);
                if (idx < got_addr.size()) begin
                    check("wr_addr", got_addr[idx], AW'(base + idx));
                    check("wr_data", got_data[idx], ed);
                end
            end
        if (!en_rand && !val_rand && n > 0 && got_cyc.size() == n * AS)
            check("contiguous", got_cyc[n*AS-1] - got_cyc[0], n * AS - 1);
`ifdef WB_CHECKSUM_EN
        check("checksum", checksum, sum);
`endif
    endtask

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bit found;
        int n;
        bus.row_valid = 0; bus.row_data = '0;
        #2 reset = 1;
        #1 check_zero();
        repeat (3) tick();
        reset = 0;
        tick();

        // Two sequential rows with a start pulse mid-job that must be ignored.
        job_rows = {seq_row(1), seq_row(10)};
        run_job(10'h010, 2, 0, 0, 0, 1);
`ifdef WB_CHECKSUM_EN
        check("checksum_171", checksum, 171);
`endif

        // Empty job: one RUN cycle, then a single DONE cycle, no traffic.
        we_seen = 0; ready_seen = 0;
        bus.row_valid = 1; bus.row_data = rand_row();
        base_addr = 10'h155; num_rows = 0; start = 1;
        tick();
        start = 0;
        check("zero_busy", busy, 1);
        check("zero_done_early", done, 0);
        tick();
        check("zero_done", done, 1);
        check("zero_busy_in_done", busy, 0);
        tick();
        check("zero_done_cleared", done, 0);
        bus.row_valid = 0;
        tick();
        check("zero_no_write", we_seen, 0);
        check("zero_no_ready", ready_seen, 0);

        // Drain held off: FIFO fills to depth, then releases without gaps.
        job_rows = {};
        for (int r = 0; r < 6; r++) job_rows.push_back(seq_row(100 + 9 * r));
        run_job(10'h040, 6, 0, 0, 10, 0);

        // Address wrap at top of RAM.
        job_rows = {seq_row(0)};
        run_job(10'h3FC, 1, 0, 0, 0, 0);

        // Reset while the fourth lane of the first row is on the bus.
        job_rows = {rand_row(), rand_row()};
        base_addr = 10'h100; num_rows = 2; start = 1;
        tick();
        start = 0; bus.row_valid = 1; bus.row_data = job_rows[0];
        found = 0;
        for (int c = 0; c < 40 && !found; c++) begin
            @(negedge s_clk);
            found = bus.mem_we && bus.mem_addr == 10'h103;
        end
        check("reset_hit_lane3", found, 1);
        reset = 1;
        #1 check_zero();
        bus.row_valid = 0;
        repeat (2) tick();
        reset = 0;
        tick();
        job_rows = {rand_row(), rand_row()};
        run_job(10'h200, 2, 0, 0, 0, 0);

        // Random jobs with random enable and valid gaps.
        for (int k = 0; k < 6; k++) begin
            n = $urandom_range(5, 1);
            job_rows = {};
            for (int r = 0; r < n; r++) job_rows.push_back(rand_row());
            run_job(AW'($urandom), n, 1, 1, 0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
